key_input_conditioner: RTL and testbench

Front-end stage for free-play mode. It conditions the eight raw piano push-buttons into clean, debounced key levels and generates the metronome beat `trigger`. Its `keys_out` and `trigger` outputs drive the `keys_in` and `trigger` inputs of the key-press counter inside the free-play block. It also flags each new key press with a one-cycle event and a priority-encoded key code.

---
 rtl/fpiano_pkg.sv | 35 +++
 rtl/key_debouncer.sv | 72 +++++++
 rtl/key_input_conditioner.sv | 172 +++++++++++++++++
 tb/tb_key_input_conditioner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fpiano_pkg.sv
// fpiano_pkg: shared types and constants for the free-play piano front end.
//   NUM_KEYS      number of piano push-buttons
//   key_vec_t     one bit per key (bit 0 = low C ... bit 7 = high C)
//   key_idx_t     key index / key code
//   beat_state_t  metronome beat generator states
//   TEMPO_*       tempo_sel encodings (beat period = BEAT_CYCLES << tempo_sel)
//   lowest_key()  priority encoder, lowest set bit wins
package fpiano_pkg;

  localparam int NUM_KEYS = 8;

  typedef logic [7:0] key_vec_t;
  typedef logic [2:0] key_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } beat_state_t;

  localparam logic [1:0] TEMPO_X1 = 2'd0;
  localparam logic [1:0] TEMPO_X2 = 2'd1;
  localparam logic [1:0] TEMPO_X4 = 2'd2;
  localparam logic [1:0] TEMPO_X8 = 2'd3;

  // Scan from the top down so the lowest set index is the last one written.
  function automatic key_idx_t lowest_key(input key_vec_t v);
    key_idx_t idx;
    idx = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      idx = v[i] ? key_idx_t'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: one key's two-flop synchronizer plus debounce counter.
// The debounced level only follows the synchronized input after it has
// differed for DEBOUNCE_CYCLES consecutive samples; shorter glitches are
// dropped because any agreeing sample clears the counter.
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-low reset
//   i_key_raw     raw asynchronous button input
//   o_level       registered debounced level
//   o_level_next  value o_level takes at the next edge (for rise detection)
module key_debouncer
  import fpiano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 742_500
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_level_next
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_level_next;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce decision: count disagreement, accept on the cycle it would hit the limit.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    if (r_sync2 == r_level) begin
      w_cnt_next = {CW{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      w_level_next = r_sync2;
      w_cnt_next   = {CW{1'b0}};
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  // Debounce counter and accepted level.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt   <= {CW{1'b0}};
      r_level <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
    end
  end

  assign o_level      = r_level;
  assign o_level_next = w_level_next;

endmodule

// File: rtl/key_input_conditioner.sv
// key_input_conditioner: free-play front end. Debounces the eight piano
// buttons, flags each new key press with a one-cycle event plus the lowest
// rising key index, and generates the metronome beat trigger.
// Optional feature macro: METRONOME_CLICK_EN adds the CLICK_CYCLES parameter,
// the click_out port and its click counter.
// Ports:
//   clk_in     system clock
//   rst_in     asynchronous active-low reset
//   keys_raw   raw bouncy buttons, bit i = key i
//   run_in     metronome enable
//   tempo_sel  beat period = BEAT_CYCLES << tempo_sel
//   keys_out   debounced key levels
//   trigger    one-cycle beat pulse
//   key_event  one-cycle pulse when any debounced key rises
//   key_code   lowest key index that rose in the key_event cycle (held otherwise)
//   click_out  audible click after each trigger (METRONOME_CLICK_EN only)
module key_input_conditioner
  import fpiano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 742_500,
  parameter int BEAT_CYCLES     = 37_125_000
`ifdef METRONOME_CLICK_EN
  ,
  parameter int CLICK_CYCLES    = 74_250
`endif
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] keys_raw,
  input  logic       run_in,
  input  logic [1:0] tempo_sel,
  output logic [7:0] keys_out,
  output logic       trigger,
  output logic       key_event,
  output logic [2:0] key_code
`ifdef METRONOME_CLICK_EN
  ,
  output logic       click_out
`endif
);

  // Wide enough for the slowest tempo (BEAT_CYCLES << 3).
  localparam int BW = $clog2(BEAT_CYCLES * 8);

  key_vec_t    w_level;
  key_vec_t    w_level_next;
  key_vec_t    w_rise;

  beat_state_t r_state;
  beat_state_t w_state_next;
  logic [BW-1:0] r_beat_cnt;
  logic [BW-1:0] w_beat_cnt_next;
  logic [BW-1:0] w_period;
  logic [BW-1:0] w_bound;
  logic          r_trigger;
  logic          w_trigger_next;
  logic          r_key_event;
  key_idx_t      r_key_code;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .i_key_raw   (keys_raw[gi]),
      .o_level     (w_level[gi]),
      .o_level_next(w_level_next[gi])
    );
  end

  assign w_rise = w_level_next & ~w_level;

  // Key-press event and code, registered from the rising edges of the debounced levels.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_key_event <= 1'b0;
      r_key_code  <= 3'd0;
    end else begin
      r_key_event <= |w_rise;
      if (|w_rise) begin
        r_key_code <= lowest_key(w_rise);
      end else begin
        r_key_code <= r_key_code;
      end
    end
  end

  // The period follows tempo_sel live; the >= test lets a shortened period wrap at once.
  assign w_period = BW'(BEAT_CYCLES) << tempo_sel;
  assign w_bound  = w_period - BW'(1);

  // Beat FSM next state, counter and trigger.
  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_trigger_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_beat_cnt_next = {BW{1'b0}};
        if (run_in) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (!run_in) begin
          w_state_next    = IDLE;
          w_beat_cnt_next = {BW{1'b0}};
        end else if (r_beat_cnt >= w_bound) begin
          w_beat_cnt_next = {BW{1'b0}};
          w_trigger_next  = 1'b1;
        end else begin
          w_beat_cnt_next = r_beat_cnt + BW'(1);
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_beat_cnt_next = {BW{1'b0}};
      end
    endcase
  end

  // Beat FSM state, counter and registered trigger.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_beat_cnt <= {BW{1'b0}};
      r_trigger  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_trigger  <= w_trigger_next;
    end
  end

  assign keys_out  = w_level;
  assign trigger   = r_trigger;
  assign key_event = r_key_event;
  assign key_code  = r_key_code;

`ifdef METRONOME_CLICK_EN
  localparam int KW = $clog2(CLICK_CYCLES + 1);

  logic [KW-1:0] r_click_cnt;
  logic          r_click;

  // Click pulse: starts the cycle after trigger, a new trigger reloads it, silent when idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_click     <= 1'b0;
      r_click_cnt <= {KW{1'b0}};
    end else if (w_state_next == IDLE) begin
      r_click     <= 1'b0;
      r_click_cnt <= {KW{1'b0}};
    end else if (r_trigger) begin
      r_click     <= 1'b1;
      r_click_cnt <= KW'(CLICK_CYCLES - 1);
    end else if (r_click_cnt != {KW{1'b0}}) begin
      r_click_cnt <= r_click_cnt - KW'(1);
    end else begin
      r_click     <= 1'b0;
    end
  end

  assign click_out = r_click;
`else
  // Without the click option the beat is signalled by trigger alone.
`endif

endmodule

// File: tb/tb_key_input_conditioner.sv
// Self-checking bench for key_input_conditioner (DEBOUNCE=4, BEAT=10, CLICK=3).
// Expected key codes and trigger cycles are queued when stimulus is applied
// and compared when the DUT produces key_event / trigger.
module tb_key_input_conditioner;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] keys_raw;
  logic       run_in;
  logic [1:0] tempo_sel;
  logic [7:0] keys_out;
  logic       trigger;
  logic       key_event;
  logic [2:0] key_code;
`ifdef METRONOME_CLICK_EN
  logic       click_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int code_q[$];
  int trig_q[$];
  int e0;

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .BEAT_CYCLES    (10)
`ifdef METRONOME_CLICK_EN
    ,
    .CLICK_CYCLES   (3)
`endif
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .keys_raw (keys_raw),
    .run_in   (run_in),
    .tempo_sel(tempo_sel),
    .keys_out (keys_out),
    .trigger  (trigger),
    .key_event(key_event),
    .key_code (key_code)
`ifdef METRONOME_CLICK_EN
    ,
    .click_out(click_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Count rising edges; at a negedge cyc equals the number of edges so far.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  // Scoreboard: compare every key_event and trigger against queued expectations.
  always @(negedge clk_in) begin
    if (key_event) begin
      if (code_q.size() == 0) check("key_event_spurious", 1, 0);
      else check("key_code", int'(key_code), code_q.pop_front());
    end
    if (trigger) begin
      if (trig_q.size() == 0) check("trigger_spurious", cyc, -1);
      else check("trigger_cycle", cyc, trig_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; keys_raw = 8'h00; run_in = 1'b0; tempo_sel = 2'd0;
    repeat (3) @(negedge clk_in);
    check("rst_keys_out", keys_out, 0);
    check("rst_trigger", trigger, 0);
    check("rst_key_event", key_event, 0);
    check("rst_key_code", key_code, 0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Clean press of key 3: present on keys_out after the 6th edge.
    keys_raw = 8'h08; code_q.push_back(3);
    repeat (5) @(negedge clk_in);
    check("k3_early", keys_out, 8'h00);
    @(negedge clk_in);
    check("k3_level", keys_out, 8'h08);
    repeat (4) @(negedge clk_in);
    check("k3_event_seen", code_q.size(), 0);

    // Key 5 bounces 1-0-1-0, then holds 1.
    for (int i = 0; i < 4; i++) begin
      keys_raw = (i % 2 == 0) ? 8'h28 : 8'h08;
      @(negedge clk_in);
      check("k5_bounce", keys_out, 8'h08);
    end
    keys_raw = 8'h28; code_q.push_back(5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("k5_hold_wait", keys_out, 8'h08);
    end
    @(negedge clk_in);
    check("k5_level", keys_out, 8'h28);
    repeat (4) @(negedge clk_in);
    check("k5_event_seen", code_q.size(), 0);

    // Release everything: no events expected.
    keys_raw = 8'h00;
    repeat (8) @(negedge clk_in);
    check("release_35", keys_out, 8'h00);

    // Keys 2 and 6 together: one event, code 2.
    keys_raw = 8'h44; code_q.push_back(2);
    repeat (5) @(negedge clk_in);
    check("k26_early", keys_out, 8'h00);
    @(negedge clk_in);
    check("k26_level", keys_out, 8'h44);
    repeat (4) @(negedge clk_in);
    keys_raw = 8'h00;
    repeat (8) @(negedge clk_in);
    check("release_26", keys_out, 8'h00);
    check("k26_event_seen", code_q.size(), 0);

    // Beat: RUN entered at edge e0, triggers every 10 then every 20 cycles.
    run_in = 1'b1; tempo_sel = 2'd0; e0 = cyc + 1;
    trig_q.push_back(e0 + 10); trig_q.push_back(e0 + 20); trig_q.push_back(e0 + 30);
    trig_q.push_back(e0 + 50); trig_q.push_back(e0 + 70);
`ifdef METRONOME_CLICK_EN
    wait_cyc(e0 + 10);
    check("click_pre", click_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("click_on", click_out, 1);
    end
    @(negedge clk_in);
    check("click_off", click_out, 0);
`endif
    wait_cyc(e0 + 30);
    tempo_sel = 2'd1;
    wait_cyc(e0 + 75);
    run_in = 1'b0;
    wait_cyc(e0 + 120);
    check("beat_all_seen", trig_q.size(), 0);

    // Shorten period at counter 15: wrap on the next edge.
    run_in = 1'b1; tempo_sel = 2'd1; e0 = cyc + 1;
    trig_q.push_back(e0 + 16); trig_q.push_back(e0 + 26);
    wait_cyc(e0 + 15);
    tempo_sel = 2'd0;
    wait_cyc(e0 + 30);
    run_in = 1'b0;
    wait_cyc(e0 + 45);
    check("shorten_all_seen", trig_q.size(), 0);

    // Reset mid-debounce and mid-beat.
    keys_raw = 8'h02; code_q.push_back(1);
    run_in = 1'b1; tempo_sel = 2'd0; e0 = cyc + 1;
    trig_q.push_back(e0 + 10);
    wait_cyc(e0 + 12);
    check("k1_level", keys_out, 8'h02);
    keys_raw = 8'h00;
    wait_cyc(e0 + 15);
    #2 rst_in = 1'b0;
    #1;
    check("async_rst_keys_out", keys_out, 0);
    check("async_rst_key_code", key_code, 0);
    check("async_rst_trigger", trigger, 0);
    check("async_rst_key_event", key_event, 0);
    check("pre_rst_seen", trig_q.size() + code_q.size(), 0);
    trig_q.delete(); code_q.delete();
    @(negedge clk_in);
    rst_in = 1'b1; keys_raw = 8'h10; code_q.push_back(4);
    e0 = cyc + 1;
    trig_q.push_back(e0 + 10);
    wait_cyc(e0 + 4);
    check("post_rst_k4_early", keys_out, 8'h00);
    @(negedge clk_in);
    check("post_rst_k4_level", keys_out, 8'h10);
    wait_cyc(e0 + 15);
    run_in = 1'b0; keys_raw = 8'h00;
    wait_cyc(e0 + 35);
    check("post_rst_all_seen", trig_q.size() + code_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
